// File: rtl/uart_pkg.sv
// Shared constants, FSM state type and byte helpers for the UART echo checker.
package uart_pkg;

  localparam logic [7:0] LFSR_MASK = 8'hB8;
  localparam logic [7:0] LC_LO     = 8'h61;
  localparam logic [7:0] LC_HI     = 8'h7A;
  localparam logic [7:0] CASE_DIFF = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // 8-bit Galois LFSR step; a non-zero state never maps to zero.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : 8'h00);
  endfunction

  function automatic logic [7:0] to_upper(input logic [7:0] b);
    return (b >= LC_LO && b <= LC_HI) ? (b - CASE_DIFF) : b;
  endfunction

endpackage

// File: rtl/uart_expect_queue.sv
// Circular queue of expected echo bytes: wrapping pointers plus occupancy count.
module uart_expect_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_push,
  input  logic [7:0]    i_data,
  input  logic          i_pop,
  output logic [7:0]    o_head,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count
);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (!w_push && w_pop) r_count <= r_count - (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/uart_echo_checker.sv
// Host-side UART link initiator: sends an LFSR byte stream and checks the
// upper-cased echo, reporting error/receive counts, timeout and pass.
module uart_echo_checker #(
  parameter int         NUM_BYTES       = 64,
  parameter int         MAX_OUTSTANDING = 4,
  parameter int         TIMEOUT_CYCLES  = 50000,
  parameter logic [7:0] SEED            = 8'hA5
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_pass,
  output logic        o_timeout,
  output logic [15:0] o_err_count,
  output logic [15:0] o_rx_count
);
  import uart_pkg::*;

  localparam logic [7:0]  SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam int          AW       = $clog2(MAX_OUTSTANDING);
  localparam int          TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [15:0] LAST_IDX = 16'(NUM_BYTES - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_lfsr;
  logic          r_tx_valid;
  logic [15:0]   r_sent;
  logic [15:0]   r_err;
  logic [15:0]   r_rx;
  logic          r_timeout;
  logic [TW-1:0] r_to_cnt;

  logic          w_busy, w_start, w_accept, w_rx, w_pop, w_mismatch;
  logic          w_last, w_to_clr, w_to_hit;
  logic [7:0]    w_head, w_expect;
  logic          w_full, w_empty;
  logic [AW:0]   w_count, w_count_nxt;

  assign w_busy     = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign w_start    = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_accept   = r_tx_valid && i_tx_ready && !w_full;
  assign w_rx       = i_rx_valid && w_busy;
  assign w_pop      = w_rx && !w_empty;
  assign w_mismatch = w_rx && (w_empty || (i_rx_data != w_head));
  assign w_last     = w_accept && (r_sent == LAST_IDX);
  assign w_to_clr   = w_accept || i_rx_valid || w_empty;
  assign w_to_hit   = w_busy && !w_to_clr && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign w_expect   = to_upper(r_lfsr);
  // Valid is registered, so it is derived from next-cycle occupancy.
  assign w_count_nxt = w_start ? '0
                     : (w_count + (AW+1)'(w_accept) - (AW+1)'(w_pop));

  uart_expect_queue #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_queue (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (w_start),
    .i_push  (w_accept),
    .i_data  (w_expect),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_start) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (w_to_hit)    w_state_nxt = ST_DONE;
        else if (w_last) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: if (w_to_hit || w_empty) w_state_nxt = ST_DONE;
      ST_DONE:  if (w_start) w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy = w_busy;
    o_done = (r_state == ST_DONE);
    o_pass = o_done && (r_err == '0) && !r_timeout && (r_rx == 16'(NUM_BYTES));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lfsr     <= SEED_EFF;
      r_tx_valid <= 1'b0;
      r_sent     <= '0;
      r_err      <= '0;
      r_rx       <= '0;
      r_timeout  <= 1'b0;
      r_to_cnt   <= '0;
    end else begin
      r_tx_valid <= (w_state_nxt == ST_RUN) && (w_count_nxt < (AW+1)'(MAX_OUTSTANDING));
      if (w_start) begin
        r_lfsr    <= SEED_EFF;
        r_sent    <= '0;
        r_err     <= '0;
        r_rx      <= '0;
        r_timeout <= 1'b0;
        r_to_cnt  <= '0;
      end else begin
        if (w_accept) begin
          r_lfsr <= lfsr_next(r_lfsr);
          r_sent <= r_sent + 16'd1;
        end
        if (w_rx && (r_rx != '1))        r_rx  <= r_rx + 16'd1;
        if (w_mismatch && (r_err != '1)) r_err <= r_err + 16'd1;
        if (!w_busy || w_to_clr) r_to_cnt <= '0;
        else                     r_to_cnt <= r_to_cnt + TW'(1);
        if (w_to_hit) r_timeout <= 1'b1;
      end
    end
  end

  assign o_tx_data   = r_lfsr;
  assign o_tx_valid  = r_tx_valid;
  assign o_timeout   = r_timeout;
  assign o_err_count = r_err;
  assign o_rx_count  = r_rx;

endmodule

// File: tb/tb_uart_echo_checker.sv
// Bench for uart_echo_checker: directed cycle table plus responder-driven runs
// on two instances (8 bytes / timeout 100, and 64 bytes / timeout 2000).
module tb_uart_echo_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start     [2];
  logic        tx_ready  [2];
  logic [7:0]  tx_data   [2];
  logic        tx_valid  [2];
  logic [7:0]  rx_data   [2];
  logic        rx_valid  [2];
  logic        busy      [2];
  logic        done      [2];
  logic        pass      [2];
  logic        tmo       [2];
  logic [15:0] err       [2];
  logic [15:0] rxc       [2];
  logic        man_valid [2];
  logic [7:0]  man_data  [2];
  logic        resp_valid[2] = '{1'b0, 1'b0};
  logic [7:0]  resp_data [2] = '{8'h00, 8'h00};

  assign rx_valid[0] = man_valid[0] | resp_valid[0];
  assign rx_data[0]  = resp_valid[0] ? resp_data[0] : man_data[0];
  assign rx_valid[1] = man_valid[1] | resp_valid[1];
  assign rx_data[1]  = resp_valid[1] ? resp_data[1] : man_data[1];

  uart_echo_checker #(.NUM_BYTES(8), .MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(100), .SEED(8'hA5)) u_a (
    .i_clk(clk), .i_rst(rst), .i_start(start[0]),
    .o_tx_data(tx_data[0]), .o_tx_valid(tx_valid[0]), .i_tx_ready(tx_ready[0]),
    .i_rx_data(rx_data[0]), .i_rx_valid(rx_valid[0]),
    .o_busy(busy[0]), .o_done(done[0]), .o_pass(pass[0]), .o_timeout(tmo[0]),
    .o_err_count(err[0]), .o_rx_count(rxc[0]));

  uart_echo_checker #(.NUM_BYTES(64), .MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(2000), .SEED(8'hA5)) u_b (
    .i_clk(clk), .i_rst(rst), .i_start(start[1]),
    .o_tx_data(tx_data[1]), .o_tx_valid(tx_valid[1]), .i_tx_ready(tx_ready[1]),
    .i_rx_data(rx_data[1]), .i_rx_valid(rx_valid[1]),
    .o_busy(busy[1]), .o_done(done[1]), .o_pass(pass[1]), .o_timeout(tmo[1]),
    .o_err_count(err[1]), .o_rx_count(rxc[1]));

  function automatic logic [7:0] m_lfsr(input logic [7:0] s);
    return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
  endfunction

  function automatic logic [7:0] m_upper(input logic [7:0] b);
    return (b >= 8'h61 && b <= 8'h7A) ? (b - 8'h20) : b;
  endfunction

  // Responder / monitor state. mode: 0 off, 1 upper-case echo, 2 raw echo.
  int         cyc = 0;
  int         mode[2], delay[2], drop_idx[2];
  int         acc_cnt[2], rx_seen[2], idle_cyc[2], max_out[2];
  bit         stall_seen[2];
  bit         flush[2];
  logic [7:0] pd[2][64];
  int         pdue[2][64];
  int         wp[2], rp[2];

  initial forever begin
    @(posedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      flush[k] = start[k] | rst;
      if (flush[k]) begin
        acc_cnt[k] = 0; rx_seen[k] = 0; idle_cyc[k] = 0; max_out[k] = 0; stall_seen[k] = 0;
      end else begin
        if (tx_valid[k] && tx_ready[k]) begin
          if (mode[k] != 0 && acc_cnt[k] != drop_idx[k]) begin
            pd[k][wp[k]]   = (mode[k] == 1) ? m_upper(tx_data[k]) : tx_data[k];
            pdue[k][wp[k]] = cyc + delay[k];
            wp[k]          = (wp[k] + 1) % 64;
          end
          acc_cnt[k]++;
        end
        if (rx_valid[k]) rx_seen[k]++;
        if ((tx_valid[k] && tx_ready[k]) || rx_valid[k]) idle_cyc[k] = 0;
        else idle_cyc[k]++;
        if (acc_cnt[k] - rx_seen[k] > max_out[k]) max_out[k] = acc_cnt[k] - rx_seen[k];
        if (busy[k] && !tx_valid[k] && acc_cnt[k] < ((k == 0) ? 8 : 64)) stall_seen[k] = 1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (flush[k]) begin
        rp[k] = wp[k];
        resp_valid[k] = 1'b0;
      end else if (rp[k] != wp[k] && pdue[k][rp[k]] <= cyc) begin
        resp_valid[k] = 1'b1;
        resp_data[k]  = pd[k][rp[k]];
        rp[k]         = (rp[k] + 1) % 64;
      end else begin
        resp_valid[k] = 1'b0;
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse_start(input int k);
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int budget);
    int n = 0;
    while (!done[k] && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (!done[k]) begin
      n_bad++;
      $display("FAIL wait_done[%0d]: done=0 after %0d cycles, expected 1", k, budget);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".tx_valid"}, tx_valid[0], 0);
    chk({tag, ".tx_data"},  tx_data[0],  8'hA5);
    chk({tag, ".busy"},     busy[0],     0);
    chk({tag, ".done"},     done[0],     0);
    chk({tag, ".pass"},     pass[0],     0);
    chk({tag, ".timeout"},  tmo[0],      0);
    chk({tag, ".err"},      err[0],      0);
    chk({tag, ".rx"},       rxc[0],      0);
  endtask

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [7:0]  rd;
    logic        e_v;
    logic [7:0]  e_d;
    logic [15:0] e_err;
    logic [15:0] e_rx;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  function automatic vec_t mk(input logic rdy, input logic rv, input logic [7:0] rd,
                              input logic ev, input logic [7:0] ed, input int er,
                              input int rx, input logic b, input logic d);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rd = rd; v.e_v = ev; v.e_d = ed;
    v.e_err = 16'(er); v.e_rx = 16'(rx); v.e_busy = b; v.e_done = d;
    return v;
  endfunction

  vec_t       tv[16];
  int         exp_err;
  logic [7:0] s;

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0; tx_ready[k] = 1'b0; man_valid[k] = 1'b0; man_data[k] = 8'h00;
      mode[k] = 0; delay[k] = 3; drop_idx[k] = -1;
    end
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Stream from seed A5: A5 EA 75 82 41 98 4C 26 (75 echoes as 55).
    tv[0]  = mk(1, 0, 8'h00, 1, 8'hEA, 0, 0, 1, 0);
    tv[1]  = mk(1, 0, 8'h00, 1, 8'h75, 0, 0, 1, 0);
    tv[2]  = mk(0, 1, 8'hA5, 1, 8'h75, 0, 1, 1, 0);
    tv[3]  = mk(1, 1, 8'h00, 1, 8'h82, 1, 2, 1, 0);
    tv[4]  = mk(1, 0, 8'h00, 1, 8'h41, 1, 2, 1, 0);
    tv[5]  = mk(1, 0, 8'h00, 1, 8'h98, 1, 2, 1, 0);
    tv[6]  = mk(1, 0, 8'h00, 0, 8'h00, 1, 2, 1, 0);
    tv[7]  = mk(1, 0, 8'h00, 0, 8'h00, 1, 2, 1, 0);
    tv[8]  = mk(1, 1, 8'h55, 1, 8'h4C, 1, 3, 1, 0);
    tv[9]  = mk(1, 1, 8'h82, 1, 8'h26, 1, 4, 1, 0);
    tv[10] = mk(1, 1, 8'h41, 0, 8'h00, 1, 5, 1, 0);
    tv[11] = mk(1, 1, 8'h98, 0, 8'h00, 1, 6, 1, 0);
    tv[12] = mk(1, 1, 8'h4C, 0, 8'h00, 1, 7, 1, 0);
    tv[13] = mk(1, 1, 8'h26, 0, 8'h00, 1, 8, 1, 0);
    tv[14] = mk(1, 0, 8'h00, 0, 8'h00, 1, 8, 0, 1);
    tv[15] = mk(1, 1, 8'h41, 0, 8'h00, 1, 8, 0, 1);

    pulse_start(0);
    chk("start.tx_valid", tx_valid[0], 1);
    chk("start.tx_data",  tx_data[0],  8'hA5);
    for (int i = 0; i < 16; i++) begin
      tx_ready[0] = tv[i].rdy; man_valid[0] = tv[i].rv; man_data[0] = tv[i].rd;
      @(negedge clk);
      chk($sformatf("vec%0d.tx_valid", i), tx_valid[0], tv[i].e_v);
      if (tv[i].e_v) chk($sformatf("vec%0d.tx_data", i), tx_data[0], tv[i].e_d);
      chk($sformatf("vec%0d.err", i),  err[0],  tv[i].e_err);
      chk($sformatf("vec%0d.rx", i),   rxc[0],  tv[i].e_rx);
      chk($sformatf("vec%0d.busy", i), busy[0], tv[i].e_busy);
      chk($sformatf("vec%0d.done", i), done[0], tv[i].e_done);
    end
    man_valid[0] = 1'b0;
    chk("table.pass", pass[0], 0);
    chk("table.timeout", tmo[0], 0);

    // Clean upper-case echo, 3-cycle delay.
    mode[0] = 1; delay[0] = 3; drop_idx[0] = -1; tx_ready[0] = 1'b1;
    pulse_start(0);
    wait_done(0, 500);
    chk("echo.pass", pass[0], 1);
    chk("echo.err", err[0], 0);
    chk("echo.rx", rxc[0], 8);
    chk("echo.timeout", tmo[0], 0);

    // Fifth byte never echoed: timeout 100 cycles after the last strobe.
    drop_idx[0] = 4;
    pulse_start(0);
    wait_done(0, 1000);
    chk("drop.idle_cycles", idle_cyc[0], 100);
    chk("drop.timeout", tmo[0], 1);
    chk("drop.rx", rxc[0], 7);
    chk("drop.pass", pass[0], 0);

    // Ready held low: offered byte must stay put.
    mode[0] = 0; drop_idx[0] = -1; tx_ready[0] = 1'b0;
    pulse_start(0);
    for (int i = 0; i < 50; i++) begin
      chk($sformatf("stall%0d.tx_valid", i), tx_valid[0], 1);
      chk($sformatf("stall%0d.tx_data", i),  tx_data[0],  8'hA5);
      @(negedge clk);
    end
    man_valid[0] = 1'b1; man_data[0] = 8'h41;
    @(negedge clk);
    man_valid[0] = 1'b0;
    chk("unsolicited.err", err[0], 1);
    chk("unsolicited.rx", rxc[0], 1);
    chk("unsolicited.timeout", tmo[0], 0);

    // Start while busy is ignored: stream and counters keep going.
    tx_ready[0] = 1'b1;
    repeat (2) @(negedge clk);
    tx_ready[0] = 1'b0;
    chk("busy_start.pre_data", tx_data[0], 8'h75);
    pulse_start(0);
    chk("busy_start.busy", busy[0], 1);
    chk("busy_start.data", tx_data[0], 8'h75);
    chk("busy_start.rx", rxc[0], 1);
    chk("busy_start.err", err[0], 1);

    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("mid_reset");
    rst = 1'b0;
    @(negedge clk);

    // Raw loopback: every lower-case-range byte is a mismatch.
    s = 8'hA5; exp_err = 0;
    for (int i = 0; i < 64; i++) begin
      if (s >= 8'h61 && s <= 8'h7A) exp_err++;
      s = m_lfsr(s);
    end
    mode[1] = 2; delay[1] = 3; tx_ready[1] = 1'b1;
    pulse_start(1);
    wait_done(1, 3000);
    chk("loop.err", err[1], exp_err);
    chk("loop.rx", rxc[1], 64);
    chk("loop.pass", pass[1], 0);
    chk("loop.timeout", tmo[1], 0);

    // Slow echo: queue depth limits bytes in flight.
    mode[1] = 1; delay[1] = 1000;
    pulse_start(1);
    wait_done(1, 30000);
    chk("slow.max_outstanding", max_out[1], 4);
    chk("slow.stall_seen", stall_seen[1], 1);
    chk("slow.pass", pass[1], 1);
    chk("slow.err", err[1], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
